hub75_row_shifter: RTL and testbench

//  Downstream stage of the display driver. Accepts one row pair (top + bottom half) of 1-bit RGB columns per handshake.

---
 rtl/hub75_row_shifter.sv | 210 +++++++++++++++++++++
 tb/tb_hub75_row_shifter.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/hub75_row_shifter.sv
// HUB75 row shifter: serialises one captured row pair onto the panel data lines, then blanks, updates address, latches and holds lit.
// Latency: first column on the data lines one cycle after accept; ready returns 1+2T*NUM_COLS+2T+ON_CYCLES cycles after accept.
// Backpressure: row_ready_out is low from the cycle after accept until the lit-hold period ends; row_valid_in is ignored while busy.
module hub75_row_shifter #(
    parameter int NUM_COLS     = 64,
    parameter int WRITE_FREQ   = 1_000_000,
    parameter int SYS_CLK_FREQ = 100_000_000,
    parameter int ON_CYCLES    = 256
) (
    input  logic                         clk_in,
    input  logic                         reset_in,
    input  logic                         row_valid_in,
    output logic                         row_ready_out,
    input  logic [3:0]                   row_addr_in,
    input  logic [2:0][NUM_COLS-1:0]     col_top_in,
    input  logic [2:0][NUM_COLS-1:0]     col_bot_in,
    output logic [2:0]                   rgb_top_out,
    output logic [2:0]                   rgb_bot_out,
    output logic                         bit_clk_out,
    output logic                         latch_out,
    output logic                         oe_n_out,
    output logic [3:0]                   addr_out
);

    // Half bit-clock period in clk_in cycles; every shift/blank/latch phase lasts this long.
    localparam int T_CYC  = SYS_CLK_FREQ / (2 * WRITE_FREQ);
    localparam int PH_MAX = (T_CYC > ON_CYCLES) ? T_CYC : ON_CYCLES;
    localparam int PH_W   = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;
    localparam int COL_W  = $clog2(NUM_COLS);

    localparam logic [PH_W-1:0]  T_LOAD   = PH_W'(T_CYC - 1);
    localparam logic [PH_W-1:0]  ON_LOAD  = PH_W'((ON_CYCLES > 0) ? ON_CYCLES - 1 : 0);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(NUM_COLS - 1);

    if (T_CYC < 1) begin : g_bad_t
        $error("hub75_row_shifter: SYS_CLK_FREQ/(2*WRITE_FREQ) must be at least 1");
    end
    if (NUM_COLS < 2) begin : g_bad_cols
        $error("hub75_row_shifter: NUM_COLS must be at least 2");
    end

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        SHIFT_LO = 3'd1,
        SHIFT_HI = 3'd2,
        BLANK    = 3'd3,
        LATCH    = 3'd4,
        HOLD     = 3'd5
    } state_t;

    state_t                     state_q, state_d;
    logic [PH_W-1:0]            ph_q, ph_d;
    logic [COL_W-1:0]           col_q, col_d;
    logic [2:0][NUM_COLS-1:0]   top_q, top_d;
    logic [2:0][NUM_COLS-1:0]   bot_q, bot_d;
    logic [3:0]                 row_addr_q, row_addr_d;
    logic                       ready_q, ready_d;
    logic [2:0]                 rgb_top_q, rgb_top_d;
    logic [2:0]                 rgb_bot_q, rgb_bot_d;
    logic                       bit_clk_q, bit_clk_d;
    logic                       latch_q, latch_d;
    logic                       oe_n_q, oe_n_d;
    logic [3:0]                 addr_q, addr_d;

    // Next-state and next-output logic; phase counter counts down from its load value to zero.
    always_comb begin
        state_d    = state_q;
        ph_d       = ph_q;
        col_d      = col_q;
        top_d      = top_q;
        bot_d      = bot_q;
        row_addr_d = row_addr_q;
        ready_d    = ready_q;
        rgb_top_d  = rgb_top_q;
        rgb_bot_d  = rgb_bot_q;
        bit_clk_d  = bit_clk_q;
        latch_d    = latch_q;
        oe_n_d     = oe_n_q;
        addr_d     = addr_q;

        case (state_q)
            IDLE: begin
                ready_d = 1'b1;
                if (row_valid_in && ready_q) begin
                    top_d      = col_top_in;
                    bot_d      = col_bot_in;
                    row_addr_d = row_addr_in;
                    ready_d    = 1'b0;
                    state_d    = SHIFT_LO;
                    ph_d       = T_LOAD;
                    col_d      = COL_LAST;
                    bit_clk_d  = 1'b0;
                    for (int c = 0; c < 3; c++) begin
                        rgb_top_d[c] = col_top_in[c][NUM_COLS-1];
                        rgb_bot_d[c] = col_bot_in[c][NUM_COLS-1];
                    end
                end
            end
            SHIFT_LO: begin
                if (ph_q == '0) begin
                    state_d   = SHIFT_HI;
                    ph_d      = T_LOAD;
                    bit_clk_d = 1'b1;
                end else begin
                    ph_d = ph_q - 1'b1;
                end
            end
            SHIFT_HI: begin
                if (ph_q != '0) begin
                    ph_d = ph_q - 1'b1;
                end else if (col_q != '0) begin
                    col_d     = col_q - 1'b1;
                    state_d   = SHIFT_LO;
                    ph_d      = T_LOAD;
                    bit_clk_d = 1'b0;
                    for (int c = 0; c < 3; c++) begin
                        rgb_top_d[c] = top_q[c][col_d];
                        rgb_bot_d[c] = bot_q[c][col_d];
                    end
                end else begin
                    // Blank before touching the address so the panel never shows a row at the wrong address.
                    state_d   = BLANK;
                    ph_d      = T_LOAD;
                    bit_clk_d = 1'b0;
                    rgb_top_d = '0;
                    rgb_bot_d = '0;
                    oe_n_d    = 1'b1;
                    addr_d    = row_addr_q;
                end
            end
            BLANK: begin
                if (ph_q == '0) begin
                    state_d = LATCH;
                    ph_d    = T_LOAD;
                    latch_d = 1'b1;
                end else begin
                    ph_d = ph_q - 1'b1;
                end
            end
            LATCH: begin
                if (ph_q == '0) begin
                    latch_d = 1'b0;
                    oe_n_d  = 1'b0;
                    if (ON_CYCLES > 0) begin
                        state_d = HOLD;
                        ph_d    = ON_LOAD;
                    end else begin
                        state_d = IDLE;
                        ready_d = 1'b1;
                    end
                end else begin
                    ph_d = ph_q - 1'b1;
                end
            end
            HOLD: begin
                if (ph_q == '0) begin
                    state_d = IDLE;
                    ready_d = 1'b1;
                end else begin
                    ph_d = ph_q - 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and registered outputs; reset forces the panel blanked and the block not ready.
    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            state_q    <= IDLE;
            ph_q       <= '0;
            col_q      <= '0;
            top_q      <= '0;
            bot_q      <= '0;
            row_addr_q <= '0;
            ready_q    <= 1'b0;
            rgb_top_q  <= '0;
            rgb_bot_q  <= '0;
            bit_clk_q  <= 1'b0;
            latch_q    <= 1'b0;
            oe_n_q     <= 1'b1;
            addr_q     <= '0;
        end else begin
            state_q    <= state_d;
            ph_q       <= ph_d;
            col_q      <= col_d;
            top_q      <= top_d;
            bot_q      <= bot_d;
            row_addr_q <= row_addr_d;
            ready_q    <= ready_d;
            rgb_top_q  <= rgb_top_d;
            rgb_bot_q  <= rgb_bot_d;
            bit_clk_q  <= bit_clk_d;
            latch_q    <= latch_d;
            oe_n_q     <= oe_n_d;
            addr_q     <= addr_d;
        end
    end

    assign row_ready_out = ready_q;
    assign rgb_top_out   = rgb_top_q;
    assign rgb_bot_out   = rgb_bot_q;
    assign bit_clk_out   = bit_clk_q;
    assign latch_out     = latch_q;
    assign oe_n_out      = oe_n_q;
    assign addr_out      = addr_q;

endmodule

// File: tb/tb_hub75_row_shifter.sv
// Testbench for hub75_row_shifter: two instances (ON_CYCLES=3 and ON_CYCLES=0) share stimulus.
// Each cycle the outputs of both are compared against a timeline model derived from the row timing rules.
// Stimulus: directed first row, back-to-back rows with valid held high, mid-shift reset, then random traffic.
module tb_hub75_row_shifter;

    localparam int NC = 4;
    localparam int T  = 2;

    typedef struct packed {
        logic       rdy;
        logic [2:0] top;
        logic [2:0] bot;
        logic       bclk;
        logic       lat;
        logic       oe_n;
        logic [3:0] addr;
    } obs_t;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 row_valid = 1'b0;
    logic [3:0]           row_addr = '0;
    logic [2:0][NC-1:0]   col_top = '0;
    logic [2:0][NC-1:0]   col_bot = '0;

    logic       rdy_o  [2];
    logic [2:0] top_o  [2];
    logic [2:0] bot_o  [2];
    logic       bclk_o [2];
    logic       lat_o  [2];
    logic       oen_o  [2];
    logic [3:0] addr_o [2];

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    // Reference model state, one set per instance
    int                 on_c [2] = '{3, 0};
    bit                 m_busy [2];
    int                 m_a    [2];
    logic [2:0][NC-1:0] m_top  [2];
    logic [2:0][NC-1:0] m_bot  [2];
    logic [3:0]         m_cap  [2];
    logic [3:0]         m_addr [2];
    logic               m_oe   [2];
    logic               m_rdy  [2];

    always #5 clk = ~clk;

    hub75_row_shifter #(
        .NUM_COLS(NC), .WRITE_FREQ(25_000_000), .SYS_CLK_FREQ(100_000_000), .ON_CYCLES(3)
    ) dut (
        .clk_in(clk), .reset_in(rst), .row_valid_in(row_valid), .row_ready_out(rdy_o[0]),
        .row_addr_in(row_addr), .col_top_in(col_top), .col_bot_in(col_bot),
        .rgb_top_out(top_o[0]), .rgb_bot_out(bot_o[0]), .bit_clk_out(bclk_o[0]),
        .latch_out(lat_o[0]), .oe_n_out(oen_o[0]), .addr_out(addr_o[0])
    );

    hub75_row_shifter #(
        .NUM_COLS(NC), .WRITE_FREQ(25_000_000), .SYS_CLK_FREQ(100_000_000), .ON_CYCLES(0)
    ) dut_on0 (
        .clk_in(clk), .reset_in(rst), .row_valid_in(row_valid), .row_ready_out(rdy_o[1]),
        .row_addr_in(row_addr), .col_top_in(col_top), .col_bot_in(col_bot),
        .rgb_top_out(top_o[1]), .rgb_bot_out(bot_o[1]), .bit_clk_out(bclk_o[1]),
        .latch_out(lat_o[1]), .oe_n_out(oen_o[1]), .addr_out(addr_o[1])
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cycle=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    function automatic obs_t sample(input int d);
        obs_t g;
        g.rdy  = rdy_o[d];
        g.top  = top_o[d];
        g.bot  = bot_o[d];
        g.bclk = bclk_o[d];
        g.lat  = lat_o[d];
        g.oe_n = oen_o[d];
        g.addr = addr_o[d];
        return g;
    endfunction

    task automatic compare_obs(input int d, input obs_t e, input obs_t g);
        check_eq($sformatf("u%0d_ready", d), 32'(g.rdy),  32'(e.rdy));
        check_eq($sformatf("u%0d_rgb_top", d), 32'(g.top), 32'(e.top));
        check_eq($sformatf("u%0d_rgb_bot", d), 32'(g.bot), 32'(e.bot));
        check_eq($sformatf("u%0d_bit_clk", d), 32'(g.bclk), 32'(e.bclk));
        check_eq($sformatf("u%0d_latch", d), 32'(g.lat),  32'(e.lat));
        check_eq($sformatf("u%0d_oe_n", d), 32'(g.oe_n), 32'(e.oe_n));
        check_eq($sformatf("u%0d_addr", d), 32'(g.addr), 32'(e.addr));
    endtask

    // Expected outputs for the current cycle, from the offset o since the accept cycle:
    // o in 1..2T*NC shifting (column NC-1 first, low then high half), then T blank, T latch,
    // ON hold, and ready again at o = 2T*NC + 2T + ON + 1.
    task automatic model_cycle(input int d, output obs_t e);
        int o, sh_end, bl_end, la_end, end_c, k;
        e      = '0;
        e.oe_n = m_oe[d];
        e.addr = m_addr[d];
        e.rdy  = m_rdy[d];
        if (m_busy[d]) begin
            o      = cyc - m_a[d];
            sh_end = 2 * T * NC;
            bl_end = sh_end + T;
            la_end = bl_end + T;
            end_c  = la_end + on_c[d] + 1;
            e.rdy  = 1'b0;
            if (o >= end_c) begin
                m_busy[d] = 0;
                m_rdy[d]  = 1'b1;
                m_oe[d]   = 1'b0;
                e.rdy     = 1'b1;
                e.oe_n    = 1'b0;
            end else if (o <= sh_end) begin
                k = NC - 1 - (o - 1) / (2 * T);
                for (int c = 0; c < 3; c++) begin
                    e.top[c] = m_top[d][c][k];
                    e.bot[c] = m_bot[d][c][k];
                end
                e.bclk = (((o - 1) % (2 * T)) >= T);
            end else if (o <= bl_end) begin
                m_oe[d]   = 1'b1;
                m_addr[d] = m_cap[d];
                e.oe_n    = 1'b1;
                e.addr    = m_cap[d];
            end else if (o <= la_end) begin
                e.lat  = 1'b1;
                e.oe_n = 1'b1;
            end else begin
                m_oe[d] = 1'b0;
                e.oe_n  = 1'b0;
            end
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_busy[d] = 0;
            m_rdy[d]  = 1'b0;
            m_oe[d]   = 1'b1;
            m_addr[d] = '0;
        end
    endtask

    // One clock cycle: check outputs mid-cycle, then drive inputs for the next edge and update the model.
    task automatic cycle(input logic v, input logic [3:0] a, input logic [11:0] t,
                         input logic [11:0] b, input logic r);
        obs_t e;
        obs_t rst_vals;
        logic was_rst;
        @(negedge clk);
        cyc++;
        for (int d = 0; d < 2; d++) begin
            model_cycle(d, e);
            compare_obs(d, e, sample(d));
        end
        was_rst   = rst;
        row_valid = v;
        row_addr  = a;
        col_top   = t;
        col_bot   = b;
        rst       = r;
        for (int d = 0; d < 2; d++) begin
            if (r) begin
                m_busy[d] = 0;
                m_rdy[d]  = 1'b0;
                m_oe[d]   = 1'b1;
                m_addr[d] = '0;
            end else if (was_rst) begin
                m_rdy[d] = 1'b1;
            end else if (v && m_rdy[d] && !m_busy[d]) begin
                m_busy[d] = 1;
                m_a[d]    = cyc;
                m_top[d]  = t;
                m_bot[d]  = b;
                m_cap[d]  = a;
                m_rdy[d]  = 1'b0;
            end
        end
        if (r && !was_rst) begin
            #1;
            rst_vals      = '0;
            rst_vals.oe_n = 1'b1;
            for (int d = 0; d < 2; d++) compare_obs(d, rst_vals, sample(d));
        end
    endtask

    task automatic rand_cycle(input logic v, input logic r);
        cycle(v, 4'($urandom), 12'($urandom), 12'($urandom), r);
    endtask

    initial begin
        model_reset();
        // Reset held, then released with no valid
        for (int i = 0; i < 3; i++) rand_cycle(1'b0, 1'b1);
        rand_cycle(1'b0, 1'b0);
        // Directed row: R top = 1010, G bottom = 0011, address 5
        cycle(1'b1, 4'd5, 12'h00A, 12'h030, 1'b0);
        // Valid held high with data changing every cycle: back-to-back rows, no capture while busy
        for (int i = 0; i < 70; i++) rand_cycle(1'b1, 1'b0);
        for (int i = 0; i < 30; i++) rand_cycle(1'b0, 1'b0);
        // Reset pulse six cycles into a shift, then a fresh row
        rand_cycle(1'b1, 1'b0);
        for (int i = 0; i < 5; i++) rand_cycle(1'b0, 1'b0);
        rand_cycle(1'b0, 1'b1);
        rand_cycle(1'b0, 1'b0);
        rand_cycle(1'b1, 1'b0);
        for (int i = 0; i < 30; i++) rand_cycle(1'b0, 1'b0);
        // Random traffic with occasional resets
        for (int i = 0; i < 600; i++)
            rand_cycle($urandom_range(0, 3) != 0, $urandom_range(0, 149) == 0);
        rand_cycle(1'b0, 1'b0);
        for (int i = 0; i < 30; i++) rand_cycle(1'b0, 1'b0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
